// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing control for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Tracks the destination registers of the instructions in EX, MEM and WB,
//   drives operand forwarding selects, inserts load-use stalls, flushes IF/ID
//   on a taken branch and freezes the pipeline while data memory is busy.
//
// Parameters
//   MEM_TIMEOUT  cycles allowed for mem_ack before mem_err is raised
//   CNT_W        width of the stall_cycles counter
//
// Ports
//   clk, reset                      clock, synchronous active-low reset
//   id_valid/rn/rm/use_rn/use_rm    instruction currently in ID and its sources
//   id_rd/id_wr/id_load             its destination, write enable and load flag
//   ex_br_taken                     branch in EX resolved taken this cycle
//   mem_req/mem_ack                 data memory handshake from the MEM stage
//   pc_we/ifid_we                   PC and IF/ID register enables
//   ifid_flush/idex_bubble          NOP injection into IF/ID and ID/EX
//   pipe_hold                       freeze ID/EX, EX/MEM and MEM/WB
//   fwd_a/fwd_b                     operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   mem_err                         one-cycle pulse on memory timeout
//   stall_cycles                    saturating count of cycles with pc_we=0

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t state, state_next;

  logic [WAIT_W-1:0] wait_cnt;

  // Destination tracking for EX, MEM and WB. Only EX needs the load flag:
  // load-use is detected while the load sits in EX, later stages just forward.
  logic       ex_valid, ex_wr, ex_load;
  logic [3:0] ex_rd;
  logic       mem_valid, mem_wr;
  logic [3:0] mem_rd;
  logic       wb_valid, wb_wr;
  logic [3:0] wb_rd;

  logic mem_miss;
  logic timeout;
  logic load_use;

  assign mem_miss = mem_req & ~mem_ack;
  assign timeout  = (wait_cnt == WAIT_LAST);

  assign load_use = ex_valid & ex_load & ex_wr &
                    ((id_use_rn & (ex_rd == id_rn)) |
                     (id_use_rm & (ex_rd == id_rm)));

  // Youngest producer wins; R15 (PC) is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && src != 4'd15) begin
      if (ex_valid && ex_wr && ex_rd == src)
        sel = 2'b01;
      else if (mem_valid && mem_wr && mem_rd == src)
        sel = 2'b10;
      else if (wb_valid && wb_wr && wb_rd == src)
        sel = 2'b11;
    end
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset)
      state <= RUN;
    else
      state <= state_next;
  end

  // Next-state logic; a timeout returns to RUN exactly like an ack
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_miss) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ack || timeout) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Output logic. A memory miss outranks the branch, which outranks load-use.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    mem_err     = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      fwd_a = fwd_sel(id_rn, id_use_rn);
      fwd_b = fwd_sel(id_rm, id_use_rm);
      case (state)
        RUN: begin
          if (mem_miss) begin
            pipe_hold = 1'b1;
          end else if (ex_br_taken) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            idex_bubble = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        MEM_WAIT: begin
          // The back end advances on the ack or timeout cycle; IF/ID stays put.
          pipe_hold = ~(mem_ack | timeout);
          mem_err   = ~mem_ack & timeout;
        end
        default: ;
      endcase
    end
  end

  // Memory wait counter; the miss cycle in RUN counts as the first wait cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: if (mem_miss) wait_cnt <= WAIT_W'(1);
        MEM_WAIT: begin
          if (mem_ack || timeout)
            wait_cnt <= '0;
          else
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  // Destination tracking shifts only when the back end advances
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= 4'd0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 4'd0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_rd     <= 4'd0;
    end else if (!pipe_hold) begin
      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_rd    <= ex_rd;
      if (idex_bubble || !id_valid) begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_load  <= 1'b0;
        ex_rd    <= 4'd0;
      end else begin
        ex_valid <= 1'b1;
        ex_wr    <= id_wr;
        ex_load  <= id_load;
        ex_rd    <= id_rd;
      end
    end
  end

  // Stall counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cycles <= '0;
    else if (!pc_we && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed test of pipeline_hazard_ctrl with hand-computed expectations.
//   A second instance with a 2-bit stall counter shares all inputs so the
//   saturation of stall_cycles can be observed alongside the main instance.

module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm, id_wr, id_load;
  logic       ex_br_taken, mem_req, mem_ack;

  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_pipe_hold, s_mem_err;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cycles;

  logic [5:0] ctrl;
  assign ctrl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, mem_err};

  int checks = 0;
  int passes = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .pipe_hold(s_pipe_hold),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err),
    .stall_cycles(s_stall_cycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drives one cycle of inputs at the falling edge; checks follow 1ns later,
  // well before the next rising edge commits the state.
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [3:0] rn, input logic [3:0] rm,
                               input logic urn, input logic urm,
                               input logic [3:0] rd, input logic wr, input logic ld,
                               input logic br, input logic mreq, input logic mack);
    @(negedge clk);
    reset       = rst;
    id_valid    = v;
    id_rn       = rn;
    id_rm       = rm;
    id_use_rn   = urn;
    id_use_rm   = urm;
    id_rd       = rd;
    id_wr       = wr;
    id_load     = ld;
    ex_br_taken = br;
    mem_req     = mreq;
    mem_ack     = mack;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rn = 4'd0; id_rm = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_rd = 4'd0; id_wr = 1'b0;
    id_load = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

    // Reset: outputs forced regardless of inputs
    applyStimulus(0, 1, 4'd5, 4'd5, 1, 1, 4'd5, 1, 1, 1, 1, 0);
    applyStimulus(0, 1, 4'd5, 4'd5, 1, 1, 4'd5, 1, 1, 1, 1, 0);
    checkOutput("reset_ctrl", 32'(ctrl), 32'b001100);
    checkOutput("reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    checkOutput("reset_stall", 32'(stall_cycles), 32'd0);

    // ADD r5 enters EX
    applyStimulus(1, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 0, 0, 0, 0);
    checkOutput("run_ctrl", 32'(ctrl), 32'b110000);
    // ID reads r5 -> EX forward; rm=r1 has no producer
    applyStimulus(1, 1, 4'd5, 4'd1, 1, 1, 4'd6, 1, 0, 0, 0, 0);
    checkOutput("fwd_ex_a", 32'(fwd_a), 32'd1);
    checkOutput("fwd_rf_b", 32'(fwd_b), 32'd0);
    checkOutput("fwd_ex_ctrl", 32'(ctrl), 32'b110000);
    // LDR r2 in ID; it reads r5 (now MEM) and r6 (now EX)
    applyStimulus(1, 1, 4'd5, 4'd6, 1, 1, 4'd2, 1, 1, 0, 0, 0);
    checkOutput("fwd_mem_a", 32'(fwd_a), 32'd2);
    checkOutput("fwd_ex_b", 32'(fwd_b), 32'd1);
    // Consumer of r2 right behind the load: one stall cycle
    applyStimulus(1, 1, 4'd0, 4'd2, 0, 1, 4'd7, 1, 0, 0, 0, 0);
    checkOutput("loaduse_ctrl", 32'(ctrl), 32'b000100);
    checkOutput("loaduse_stall_before", 32'(stall_cycles), 32'd0);
    applyStimulus(1, 1, 4'd0, 4'd2, 0, 1, 4'd7, 1, 0, 0, 0, 0);
    checkOutput("loaduse_resume_ctrl", 32'(ctrl), 32'b110000);
    checkOutput("loaduse_fwd_b_mem", 32'(fwd_b), 32'd2);
    checkOutput("loaduse_stall_after", 32'(stall_cycles), 32'd1);
    checkOutput("sat_stall_1", 32'(s_stall_cycles), 32'd1);

    // Two writers of r3, then a writer of r15
    applyStimulus(1, 1, 4'd0, 4'd0, 0, 0, 4'd3, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 4'd0, 4'd0, 0, 0, 4'd3, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 4'd0, 4'd0, 0, 0, 4'd15, 1, 0, 0, 0, 0);
    // r3 in MEM and WB -> MEM wins; r15 in EX but never forwarded
    applyStimulus(1, 1, 4'd3, 4'd15, 1, 1, 4'd0, 0, 0, 0, 0, 0);
    checkOutput("fwd_mem_priority", 32'(fwd_a), 32'd2);
    checkOutput("fwd_r15", 32'(fwd_b), 32'd0);
    // r3 now only in WB; rm=r3 but unused
    applyStimulus(1, 0, 4'd3, 4'd3, 1, 0, 4'd0, 0, 0, 0, 0, 0);
    checkOutput("fwd_wb", 32'(fwd_a), 32'd3);
    checkOutput("fwd_unused", 32'(fwd_b), 32'd0);

    // Memory miss, ack on the second MEM_WAIT cycle
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("miss_ctrl", 32'(ctrl), 32'b000010);
    checkOutput("miss_stall_before", 32'(stall_cycles), 32'd1);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 1, 0);
    checkOutput("wait_ctrl_br_ignored", 32'(ctrl), 32'b000010);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 1);
    checkOutput("wait_ack_ctrl", 32'(ctrl), 32'b000000);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    checkOutput("after_ack_ctrl", 32'(ctrl), 32'b110000);
    checkOutput("after_ack_stall", 32'(stall_cycles), 32'd4);
    checkOutput("sat_stall_3", 32'(s_stall_cycles), 32'd3);

    // Request and ack together: no wait
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 1);
    checkOutput("hit_ctrl", 32'(ctrl), 32'b110000);

    // Timeout: MEM_TIMEOUT=4, no ack ever
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("to_wait1", 32'(ctrl), 32'b000010);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("to_wait2", 32'(ctrl), 32'b000010);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("to_wait3", 32'(ctrl), 32'b000010);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("to_err_pulse", 32'(ctrl), 32'b000001);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    checkOutput("to_back_run", 32'(ctrl), 32'b110000);
    checkOutput("to_stall", 32'(stall_cycles), 32'd8);
    checkOutput("sat_stall_hold", 32'(s_stall_cycles), 32'd3);

    // Branch taken with a load-use pending: branch wins
    applyStimulus(1, 1, 4'd0, 4'd0, 0, 0, 4'd4, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 4'd4, 4'd0, 1, 0, 4'd8, 1, 0, 1, 0, 0);
    checkOutput("br_pc_we", 32'(pc_we), 32'd1);
    checkOutput("br_flush", 32'(ifid_flush), 32'd1);
    checkOutput("br_bubble", 32'(idex_bubble), 32'd1);
    checkOutput("br_hold", 32'(pipe_hold), 32'd0);
    checkOutput("br_stall", 32'(stall_cycles), 32'd8);

    // Enter MEM_WAIT, then reset in the middle of it (r4 load sits in MEM)
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("pre_reset_miss", 32'(ctrl), 32'b000010);
    applyStimulus(0, 1, 4'd4, 4'd4, 1, 1, 4'd0, 0, 0, 0, 1, 0);
    checkOutput("midwait_reset_ctrl", 32'(ctrl), 32'b001100);
    checkOutput("midwait_reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    checkOutput("post_reset_run", 32'(ctrl), 32'b110000);
    checkOutput("post_reset_stall", 32'(stall_cycles), 32'd0);
    checkOutput("post_reset_sat_stall", 32'(s_stall_cycles), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
